seven_seg_scan_decoder: RTL and testbench
=========================================

// Module: seven_seg_scan_decoder
// PURPOSE
//  Reader for the multiplexed seven-segment display bus: samples scanned digit-select and
//  segment lines, filters scan/glitch transients, inverts the hex->segment encoding and
//  reassembles a NUM_DIGITS-nibble word. Serves as a bench monitor and board loop-back
//  checker for the display path (FP adder result readout).
// PARAMETERS
//  NUM_DIGITS     8   digits on the scanned bus (1..8)
//  STABLE_CYCLES  4   consecutive identical samples required before capture (1..255)
// PORTS
//  clk        in   1             single clock, all logic on rising edge
//  rst        in   1             synchronous, active-high reset
//  SegIn      in   7             segment lines, active-low, bit0=a .. bit6=g
//  DigSel     in   NUM_DIGITS    digit select, active-low one-hot, bit0 = least significant digit
//  Dout       out  4*NUM_DIGITS  decoded word, digit i at Dout[4i+3:4i]
//  DoutValid  out  1             one-cycle pulse when Dout is updated
//  DigitErr   out  NUM_DIGITS    per-digit unknown-pattern flags, valid with Dout
//  SelErr     out  1             one-cycle pulse: stable DigSel that is not one-hot and not all-ones
// BEHAVIOUR
//  Reset: Dout=0, DoutValid=0, DigitErr=0, SelErr=0, mask/shadow/counter cleared, FSM=SETTLING.
//  Reset mid-frame discards the partial frame; the next frame needs every digit again.
//  Stage 0: {DigSel,SegIn} registered once (smp); previous sample kept (smp_d).
//  Filter FSM:
//   SETTLING: smp==smp_d -> cnt++; smp!=smp_d -> cnt=1. When cnt reaches STABLE_CYCLES ->
//             one capture strobe, go LOCKED.
//   LOCKED:   no further strobes; smp!=smp_d -> cnt=1, go SETTLING.
//   STABLE_CYCLES=1: strobe on the first sample after every change.
//  Capture strobe, by smp DigSel:
//   all-ones -> blanking interval, ignored, no error.
//   one-hot index i -> shadow[i]=decode(SegIn), errsh[i]=unknown, mask[i]=1. A repeat
//     capture of i before the frame completes overwrites shadow[i] (latest wins).
//   any other value -> SelErr pulse in the following cycle, no capture.
//  Decode: inverse of team encoding, active-low gfedcba:
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
//   Any other code -> nibble 4'h0, unknown=1.
//  Frame complete: the cycle after the strobe that makes mask all-ones -> Dout<=shadow,
//   DigitErr<=errsh, DoutValid=1 for one cycle, mask cleared. A strobe in the same cycle as
//   frame completion starts the new frame.
//  Latency: pins stable at edge k -> strobe at edge k+STABLE_CYCLES ->
//   Dout/DoutValid at edge k+STABLE_CYCLES+1.
//  Dout and DigitErr hold between frames. DoutValid and SelErr are never high for 2
//   consecutive cycles unless they are separate events.
// STRUCTURE
//  seven_seg_pkg:
//   - SEG_* code constants for 0..F, SEG_BLANK=7'h7F
//   - function seg2hex returning {unknown, nibble}; shared with the encoder bench
//  Sub-module seven_seg_pattern_decode: combinational 7->{1,4} lookup, instantiated once on smp.
//  Top holds the register stage, counter, 2-state FSM, shadow/mask/errsh, output registers.
// TESTING (NUM_DIGITS=4, STABLE_CYCLES=4 unless noted)
//  1 Reset: assert rst 2 cycles with random inputs -> Dout=0, DoutValid=0, DigitErr=0, SelErr=0.
//  2 Scan digits 0..3 with 79,24,08,0E (1,2,A,F), 6 cycles each, 2 blank cycles between ->
//    Dout=16'hFA21, DigitErr=0, exactly one DoutValid, 5 cycles after digit-3 pins settle.
//  3 Glitch: hold digit 1 pattern 3 cycles, then change -> no capture, mask unchanged, no
//    DoutValid; STABLE_CYCLES=1 build captures it.
//  4 Digit 2 driven 7'h7E, others valid -> nibble 2 = 0, DigitErr=4'b0100 with DoutValid.
//  5 DigSel=4'b1100 held 6 cycles -> single SelErr pulse, mask unchanged; then a normal
//    frame decodes correctly.
//  6 rst after digits 0,1 captured, then digits 2,3 only -> no DoutValid; a full scan ->
//    valid frame.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path: segment codes,
// filter FSM states and the segment-to-hex inverse lookup.
package seven_seg_pkg;

  // Active-low segment codes, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } filt_state_t;

  // Returns {unknown, nibble}; unrecognised codes decode to nibble 0 with unknown set
  function automatic logic [4:0] seg2hex(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      SEG_0:   res = 5'h00;
      SEG_1:   res = 5'h01;
      SEG_2:   res = 5'h02;
      SEG_3:   res = 5'h03;
      SEG_4:   res = 5'h04;
      SEG_5:   res = 5'h05;
      SEG_6:   res = 5'h06;
      SEG_7:   res = 5'h07;
      SEG_8:   res = 5'h08;
      SEG_9:   res = 5'h09;
      SEG_A:   res = 5'h0A;
      SEG_B:   res = 5'h0B;
      SEG_C:   res = 5'h0C;
      SEG_D:   res = 5'h0D;
      SEG_E:   res = 5'h0E;
      SEG_F:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder: 7 segment lines in,
// one nibble plus an unknown-pattern flag out.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       unknown
);

  assign {unknown, nibble} = seg2hex(seg);

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Monitor for a scanned seven-segment bus: samples digit select and segments,
// waits for them to settle, decodes each digit and publishes a whole word once
// every digit position has been seen.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              SegIn,
  input  logic [NUM_DIGITS-1:0]   DigSel,
  output logic [4*NUM_DIGITS-1:0] Dout,
  output logic                    DoutValid,
  output logic [NUM_DIGITS-1:0]   DigitErr,
  output logic                    SelErr
);

  localparam int         SW         = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [SW-1:0]           smp;
  logic [SW-1:0]           smp_d;
  logic [7:0]              cnt;
  logic [7:0]              cnt_next;
  filt_state_t             state;
  filt_state_t             state_next;
  logic                    changed;
  logic                    strobe;
  logic [NUM_DIGITS-1:0]   smp_sel;
  logic [6:0]              smp_seg;
  logic [NUM_DIGITS-1:0]   sel_hot;
  logic                    sel_blank;
  logic                    sel_onehot;
  logic [NUM_DIGITS-1:0]   capture;
  logic [3:0]              dec_nibble;
  logic                    dec_unknown;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   errsh;
  logic                    frame_full;

  assign smp_sel    = smp[SW-1:7];
  assign smp_seg    = smp[6:0];
  assign sel_hot    = ~smp_sel;
  assign sel_blank  = (smp_sel == '1);
  assign sel_onehot = $onehot(sel_hot);
  assign capture    = (strobe && sel_onehot) ? sel_hot : '0;
  assign frame_full = (mask == '1);

  seven_seg_pattern_decode u_decode (
    .seg     (smp_seg),
    .nibble  (dec_nibble),
    .unknown (dec_unknown)
  );

  // Input stage: one register on the pins plus the previous sample for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      smp   <= '0;
      smp_d <= '0;
    end else begin
      smp   <= {DigSel, SegIn};
      smp_d <= smp;
    end
  end

  // Filter state and stability counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLING;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Stability filter: count identical samples and emit one strobe per settled value
  always_comb begin
    changed    = (smp != smp_d);
    cnt_next   = cnt;
    state_next = state;
    strobe     = 1'b0;
    case (state)
      SETTLING: begin
        if (changed)
          cnt_next = 8'd1;
        else if (cnt != 8'hFF)
          cnt_next = cnt + 8'd1;
      end
      LOCKED: begin
        if (changed)
          cnt_next = 8'd1;
      end
      default: begin
        cnt_next = 8'd1;
      end
    endcase
    if ((state == SETTLING || changed) && cnt_next == STABLE_CNT) begin
      strobe     = 1'b1;
      state_next = LOCKED;
    end else if (changed) begin
      state_next = SETTLING;
    end
  end

  // Frame assembly: capture strobed digits into the shadow word and publish full frames
  always_ff @(posedge clk) begin
    if (rst) begin
      mask      <= '0;
      shadow    <= '0;
      errsh     <= '0;
      Dout      <= '0;
      DigitErr  <= '0;
      DoutValid <= 1'b0;
      SelErr    <= 1'b0;
    end else begin
      DoutValid <= 1'b0;
      SelErr    <= strobe && !sel_blank && !sel_onehot;
      if (frame_full) begin
        Dout      <= shadow;
        DigitErr  <= errsh;
        DoutValid <= 1'b1;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture[i]) begin
          shadow[4*i +: 4] <= dec_nibble;
          errsh[i]         <= dec_unknown;
        end
      end
      mask <= (frame_full ? '0 : mask) | capture;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: a 4-digit, 4-cycle-filter
// instance for the main scenarios and a 1-cycle-filter instance for the glitch case.
module tb_seven_seg_scan_decoder;

  typedef struct {
    logic [15:0] dout;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  SegIn;
  logic [3:0]  DigSel;
  logic [15:0] Dout;
  logic        DoutValid;
  logic [3:0]  DigitErr;
  logic        SelErr;

  logic [6:0]  seg1;
  logic [3:0]  sel1;
  logic [15:0] Dout1;
  logic        DoutValid1;
  logic [3:0]  DigitErr1;
  logic        SelErr1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int validCount = 0;
  int validCyc = 0;
  int selErrCount = 0;
  int valid1Count = 0;
  int settleCyc = 0;
  int v0;
  int s0;

  frame_t expQ[$];
  frame_t exp1Q[$];

  seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .SegIn     (SegIn),
    .DigSel    (DigSel),
    .Dout      (Dout),
    .DoutValid (DoutValid),
    .DigitErr  (DigitErr),
    .SelErr    (SelErr)
  );

  seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .SegIn     (seg1),
    .DigSel    (sel1),
    .Dout      (Dout1),
    .DoutValid (DoutValid1),
    .DigitErr  (DigitErr1),
    .SelErr    (SelErr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard side: every published frame must match the oldest expected frame
  always @(negedge clk) begin
    if (DoutValid === 1'b1) begin
      validCount++;
      validCyc = cyc;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        frame_t e;
        e = expQ.pop_front();
        checkOutput("frame_dout", 32'(Dout), 32'(e.dout));
        checkOutput("frame_err", 32'(DigitErr), 32'(e.err));
      end
    end
    if (SelErr === 1'b1) selErrCount++;
    if (DoutValid1 === 1'b1) begin
      valid1Count++;
      if (exp1Q.size() == 0) begin
        checkOutput("fast_unexpected_valid", 32'd1, 32'd0);
      end else begin
        frame_t e;
        e = exp1Q.pop_front();
        checkOutput("fast_dout", 32'(Dout1), 32'(e.dout));
        checkOutput("fast_err", 32'(DigitErr1), 32'(e.err));
      end
    end
  end

  task automatic applyStimulus(input int which, input logic [3:0] sel, input logic [6:0] seg, input int cycles);
    if (which == 0) begin
      DigSel = sel;
      SegIn  = seg;
    end else begin
      sel1 = sel;
      seg1 = seg;
    end
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scanDigit(input int which, input int idx, input logic [6:0] seg, input int hold);
    logic [3:0] one;
    one = 4'b0001 << idx;
    applyStimulus(which, ~one, seg, hold);
    applyStimulus(which, 4'hF, 7'h7F, 2);
  endtask

  task automatic pushFrame(input int which, input logic [15:0] d, input logic [3:0] e);
    frame_t f;
    f.dout = d;
    f.err  = e;
    if (which == 0) expQ.push_back(f);
    else exp1Q.push_back(f);
  endtask

  initial begin
    rst    = 1'b1;
    DigSel = 4'($urandom);
    SegIn  = 7'($urandom);
    sel1   = 4'hF;
    seg1   = 7'h7F;

    // 1: reset with random pins
    repeat (2) @(negedge clk);
    checkOutput("reset_dout", 32'(Dout), 32'h0);
    checkOutput("reset_valid", 32'(DoutValid), 32'h0);
    checkOutput("reset_digiterr", 32'(DigitErr), 32'h0);
    checkOutput("reset_selerr", 32'(SelErr), 32'h0);
    DigSel = 4'hF;
    SegIn  = 7'h7F;
    rst    = 1'b0;
    repeat (3) @(negedge clk);

    // 2: basic frame 1,2,A,F with latency check on the last digit
    $display("[TB] basic frame");
    v0 = validCount;
    pushFrame(0, 16'hFA21, 4'b0000);
    scanDigit(0, 0, 7'h79, 6);
    scanDigit(0, 1, 7'h24, 6);
    scanDigit(0, 2, 7'h08, 6);
    settleCyc = cyc + 1;
    scanDigit(0, 3, 7'h0E, 6);
    repeat (4) @(negedge clk);
    checkOutput("basic_valid_count", 32'(validCount - v0), 32'd1);
    checkOutput("basic_latency", 32'(validCyc - settleCyc), 32'd5);

    // 3: short hold on digit 1 must not capture; Dout holds meanwhile
    $display("[TB] glitch");
    v0 = validCount;
    applyStimulus(0, 4'b1101, 7'h30, 3);
    applyStimulus(0, 4'hF, 7'h7F, 6);
    scanDigit(0, 0, 7'h79, 6);
    scanDigit(0, 2, 7'h12, 6);
    scanDigit(0, 3, 7'h08, 6);
    repeat (4) @(negedge clk);
    checkOutput("glitch_no_valid", 32'(validCount - v0), 32'd0);
    checkOutput("hold_dout", 32'(Dout), 32'hFA21);
    pushFrame(0, 16'hA5C1, 4'b0000);
    scanDigit(0, 1, 7'h46, 6);
    repeat (4) @(negedge clk);
    checkOutput("glitch_valid_count", 32'(validCount - v0), 32'd1);

    // 3b: single-cycle filter captures the same 3-cycle hold
    pushFrame(1, 16'h9F46, 4'b0000);
    applyStimulus(1, 4'b1101, 7'h19, 3);
    applyStimulus(1, 4'hF, 7'h7F, 2);
    scanDigit(1, 0, 7'h02, 2);
    scanDigit(1, 2, 7'h0E, 2);
    scanDigit(1, 3, 7'h10, 2);
    repeat (3) @(negedge clk);
    checkOutput("fast_valid_count", 32'(valid1Count), 32'd1);

    // 4: unknown pattern on digit 2
    $display("[TB] unknown pattern");
    pushFrame(0, 16'h50C9, 4'b0100);
    scanDigit(0, 0, 7'h10, 6);
    scanDigit(0, 1, 7'h46, 6);
    scanDigit(0, 2, 7'h7E, 6);
    scanDigit(0, 3, 7'h12, 6);
    repeat (4) @(negedge clk);

    // 5: invalid select mid-frame gives one SelErr and leaves the mask intact
    $display("[TB] bad select");
    s0 = selErrCount;
    pushFrame(0, 16'hDB87, 4'b0000);
    scanDigit(0, 0, 7'h78, 6);
    scanDigit(0, 1, 7'h00, 6);
    applyStimulus(0, 4'b1100, 7'h40, 6);
    applyStimulus(0, 4'hF, 7'h7F, 2);
    checkOutput("selerr_count", 32'(selErrCount - s0), 32'd1);
    scanDigit(0, 2, 7'h03, 6);
    scanDigit(0, 3, 7'h21, 6);
    repeat (4) @(negedge clk);

    // 6: reset mid-frame discards captured digits
    $display("[TB] reset mid-frame");
    scanDigit(0, 0, 7'h19, 6);
    scanDigit(0, 1, 7'h06, 6);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset_dout", 32'(Dout), 32'h0);
    rst = 1'b0;
    v0 = validCount;
    scanDigit(0, 2, 7'h24, 6);
    scanDigit(0, 3, 7'h30, 6);
    repeat (4) @(negedge clk);
    checkOutput("midreset_no_valid", 32'(validCount - v0), 32'd0);
    pushFrame(0, 16'h3210, 4'b0000);
    scanDigit(0, 0, 7'h40, 6);
    scanDigit(0, 1, 7'h79, 6);
    scanDigit(0, 2, 7'h24, 6);
    scanDigit(0, 3, 7'h30, 6);
    repeat (4) @(negedge clk);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("fast_queue_empty", 32'(exp1Q.size()), 32'd0);
    checkOutput("selerr_total", 32'(selErrCount), 32'd1);
    checkOutput("valid_total", 32'(validCount), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
